// File: rtl/led_activity_ctrl.sv
// Multi-channel status LED driver.
// Each channel either stretches short activity pulses into visible flashes or
// shows a synchronised status level solid or blinking. A shared PWM stage
// dims every channel together, and the LED outputs are registered.
module led_activity_ctrl #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned HOLD      = 1000000,
  parameter int unsigned BLINK_DIV = 6000000,
  parameter int unsigned BR_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       act,
  input  logic [NCH-1:0]       lvl,
  input  logic [2*NCH-1:0]     mode,
  input  logic [BR_W-1:0]      brightness,
  output logic [NCH-1:0]       led
);

  localparam int unsigned CNT_W = $clog2(HOLD + 1);
  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] HOLD_V   = CNT_W'(HOLD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STRETCH = 2'b01;
  localparam logic [1:0] MODE_SOLID   = 2'b10;
  localparam logic [1:0] MODE_BLINK   = 2'b11;

  logic [NCH-1:0]   hold_on_c;
  logic [NCH-1:0]   lvl_m;
  logic [NCH-1:0]   lvl_s;
  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic [BR_W-1:0]  pwm_cnt;
  logic             pwm_on_c;
  logic [NCH-1:0]   core_c;

  // Per-channel hold counters: activity reloads, otherwise saturating count-down
  for (genvar g = 0; g < NCH; g++) begin : g_hold
    logic [CNT_W-1:0] cnt;

    // Reload on activity (even mid-hold), otherwise decrement towards zero
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (act[g]) begin
        cnt <= HOLD_V;
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end
    end

    assign hold_on_c[g] = (cnt != '0);
  end

  // Two-flop synchroniser for the asynchronous status levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_m <= '0;
      lvl_s <= '0;
    end else begin
      lvl_m <= lvl;
      lvl_s <= lvl_m;
    end
  end

  // Blink prescaler: phase toggles once every BLINK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Free-running PWM counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + BR_W'(1);
    end
  end

  // All-ones brightness forces the PWM fully on
  assign pwm_on_c = (brightness == {BR_W{1'b1}}) || (pwm_cnt < brightness);

  // Per-channel source selection
  always_comb begin
    core_c = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode[2*i +: 2])
        MODE_OFF:     core_c[i] = 1'b0;
        MODE_STRETCH: core_c[i] = hold_on_c[i];
        MODE_SOLID:   core_c[i] = lvl_s[i];
        MODE_BLINK:   core_c[i] = lvl_s[i] & phase;
        default:      core_c[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive, gated by the shared PWM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= '0;
    end else begin
      led <= core_c & {NCH{pwm_on_c}};
    end
  end

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Bench for led_activity_ctrl: an edge-indexed behavioural model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_led_activity_ctrl;

  localparam int NCH       = 4;
  localparam int HOLD      = 5;
  localparam int BLINK_DIV = 4;
  localparam int BR_W      = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      act;
  logic [NCH-1:0]      lvl;
  logic [2*NCH-1:0]    mode;
  logic [BR_W-1:0]     brightness;
  logic [NCH-1:0]      led;

  int n_checks = 0;
  int n_fail   = 0;

  led_activity_ctrl #(
    .NCH(NCH), .HOLD(HOLD), .BLINK_DIV(BLINK_DIV), .BR_W(BR_W)
  ) dut (
    .clk(clk), .rst(rst), .act(act), .lvl(lvl), .mode(mode),
    .brightness(brightness), .led(led)
  );

  always #5 clk = ~clk;

  // Model: n = edges since reset release; state is derived from input history
  int             n = 0;
  int             last_act [NCH];
  logic [NCH-1:0] lvl_q [$];
  logic [NCH-1:0] exp_led = '0;

  always @(posedge clk or posedge rst) begin
    logic [NCH-1:0] nxt;
    logic [NCH-1:0] smp;
    logic           phase_m;
    logic           pwm_m;
    logic           hold_m;
    logic           lvl_m;
    if (rst) begin
      n = 0;
      lvl_q.delete();
      exp_led = '0;
      for (int i = 0; i < NCH; i++) last_act[i] = -1000000;
    end else begin
      phase_m = ((n / BLINK_DIV) % 2) == 1;
      pwm_m   = (brightness == {BR_W{1'b1}}) || ((n % (1 << BR_W)) < int'(brightness));
      smp     = (n >= 2) ? lvl_q[n-2] : '0;
      nxt     = '0;
      for (int i = 0; i < NCH; i++) begin
        hold_m = (n - last_act[i]) < HOLD;
        lvl_m  = smp[i];
        case (mode[2*i +: 2])
          2'b00:   nxt[i] = 1'b0;
          2'b01:   nxt[i] = hold_m;
          2'b10:   nxt[i] = lvl_m;
          default: nxt[i] = lvl_m & phase_m;
        endcase
        nxt[i] = nxt[i] & pwm_m;
      end
      exp_led = nxt;
      for (int i = 0; i < NCH; i++) if (act[i]) last_act[i] = n + 1;
      lvl_q.push_back(lvl);
      n++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    n_checks++;
    if (led !== exp_led) begin
      n_fail++;
      $display("FAIL per_cycle t=%0t led=%b expected %b", $time, led, exp_led);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int         hi;
    logic [10:1] w10;
    logic [8:1]  w8;
    logic [6:1]  w6;
    logic [4:1]  w4;
    logic [8:1]  w8b;

    rst = 1'b1; act = '0; lvl = '0; mode = 8'b01010101; brightness = 4'hF;
    step(3);
    rst = 1'b0;
    check("reset_led", 32'(led), 32'(0));

    // Single pulse on act[0] sampled at edge 10
    step(9);
    act[0] = 1'b1;
    step(1);
    act[0] = 1'b0;
    check("t1_before_rise", 32'(led[0]), 32'(0));
    step(1);
    check("t1_rise", 32'(led[0]), 32'(1));
    check("t1_model_pin", 32'(exp_led[0]), 32'(1));
    check("t1_others", 32'(led[3:1]), 32'(0));
    hi = 1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      hi += int'(led[0]);
    end
    check("t1_width", 32'(hi), 32'(5));

    // Retrigger on act[1] three edges after the first pulse: no gap
    act[1] = 1'b1;
    step(1);
    for (int k = 1; k <= 10; k++) begin
      act[1] = (k == 3);
      step(1);
      w10[k] = led[1];
    end
    check("t2_retrigger", 32'(w10), 32'(10'b0011111111));

    // act held for 20 cycles: solid, then off exactly HOLD cycles later
    act[1] = 1'b1;
    step(20);
    act[1] = 1'b0;
    check("t2_held_solid", 32'(led[1]), 32'(1));
    for (int k = 1; k <= 8; k++) begin
      step(1);
      w8[k] = led[1];
    end
    check("t2_release_tail", 32'(w8), 32'(8'b00011111));

    // Channel 2 solid level: three edges of latency
    mode = 8'b01100101;
    lvl[2] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      w4[k] = led[2];
    end
    check("t3_lvl_latency", 32'(w4), 32'(4'b1100));

    // Channel 2 blink: half high over any 16-cycle window
    mode = 8'b01110101;
    step(2);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      hi += int'(led[2]);
    end
    check("t3_blink_duty", 32'(hi), 32'(8));
    lvl[2] = 1'b0;
    mode = 8'b01010101;
    step(4);

    // PWM dimming with act[0] held
    act[0] = 1'b1;
    brightness = 4'd4;
    step(2);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      hi += int'(led[0]);
    end
    check("t4_pwm_4of16", 32'(hi), 32'(4));
    brightness = 4'd0;
    step(1);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      hi += int'(led[0]);
    end
    check("t4_pwm_off", 32'(hi), 32'(0));
    brightness = 4'hF;
    step(1);
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      hi += int'(led[0]);
    end
    check("t4_pwm_full", 32'(hi), 32'(16));
    act[0] = 1'b0;
    step(8);

    // Switch channel 0 from off to stretch mid-hold
    mode = 8'b01010100;
    step(1);
    act[0] = 1'b1;
    step(1);
    act[0] = 1'b0;
    step(2);
    check("t5_off_mode", 32'(led[0]), 32'(0));
    mode = 8'b01010101;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      w6[k] = led[0];
    end
    check("t5_remaining_hold", 32'(w6), 32'(6'b000111));

    // Off mode ignores toggling activity
    mode = 8'b01010100;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      act[0] = k[0];
      step(1);
      hi += int'(led[0]);
    end
    act[0] = 1'b0;
    check("t5_off_toggle", 32'(hi), 32'(0));

    // Asynchronous reset mid-hold and mid-blink
    mode = 8'b01110101;
    lvl[2] = 1'b1;
    step(12);
    act[0] = 1'b1;
    step(1);
    act[0] = 1'b0;
    step(1);
    check("t6_hold_active", 32'(led[0]), 32'(1));
    #2 rst = 1'b1;
    #1 check("t6_async_clear", 32'(led), 32'(0));
    step(2);
    rst = 1'b0;
    hi = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      hi += int'(led[0]);
      w8b[k] = led[2];
    end
    check("t6_no_hold_after", 32'(hi), 32'(0));
    check("t6_blink_restart", 32'(w8b), 32'(8'b11110000));

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
